// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM bus controller.
//   - state_e        : controller FSM states
//   - AddrWDefault   : default address width (SRAM A[0:14])
//   - DataWDefault   : default data width (SRAM IO[0:31])
//   - WaitCyclesMin/Max : legal range of the strobe length parameter
//   - CntW           : width of the strobe-length down-counter
package sram_ctrl_pkg;

  localparam int unsigned AddrWDefault  = 15;
  localparam int unsigned DataWDefault  = 32;
  localparam int unsigned WaitCyclesMin = 1;
  localparam int unsigned WaitCyclesMax = 15;
  localparam int unsigned CntW          = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } state_e;

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable 4-bit down-counter that times the SRAM strobe phase.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value loaded on load_i
//   dec_i      : decrement while nonzero
//   done_o     : count is zero
module sram_wait_cnt
  import sram_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_bus_ctrl.sv
// Single-beat request controller for a 32K x 32 asynchronous SRAM bank.
// Sequences SETUP -> STROBE (WAIT_CYCLES) -> HOLD for writes; reads optionally
// skip HOLD. Build option: define SRAM_CTRL_TURNAROUND_EN to keep the HOLD cycle
// on reads (bus turnaround before a following write drives IO).
// Ports (bit 0 is MSB on all buses):
//   CLK, RST           : clock, synchronous active-high reset
//   REQ_VALID/REQ_READY: request handshake (ready only in idle)
//   REQ_WE, REQ_ADDR, REQ_WDATA : request fields, latched on accept
//   RSP_VALID, RD_DATA : one-cycle read response, data held until next read
//   A, IO, CS, OE, WE  : SRAM address, data (tri-state) and active-low strobes
module sram_bus_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = AddrWDefault,
  parameter int unsigned DATA_W      = DataWDefault
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [0:ADDR_W-1] REQ_ADDR,
  input  logic [0:DATA_W-1] REQ_WDATA,
  output logic              RSP_VALID,
  output logic [0:DATA_W-1] RD_DATA,
  output logic [0:ADDR_W-1] A,
  inout  wire  [0:DATA_W-1] IO,
  output logic              CS,
  output logic              OE,
  output logic              WE
);

  if (WAIT_CYCLES < WaitCyclesMin || WAIT_CYCLES > WaitCyclesMax) begin : g_bad_wait
    $error("sram_bus_ctrl: WAIT_CYCLES must be in 1..15");
  end

  // Counter is loaded during SETUP so STROBE lasts exactly WAIT_CYCLES cycles.
  localparam logic [CntW-1:0] StrobeLoad = CntW'(WAIT_CYCLES - 1);

  state_e            state_q;
  logic              wr_q;
  logic [0:DATA_W-1] wdata_q;
  logic              io_drv_q;
  logic [0:ADDR_W-1] a_q;
  logic              cs_q;
  logic              oe_q;
  logic              we_q;
  logic              rsp_valid_q;
  logic [0:DATA_W-1] rd_data_q;
  logic              cnt_done;

  sram_wait_cnt u_wait_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (state_q == StSetup),
    .load_val_i (StrobeLoad),
    .dec_i      (state_q == StStrobe),
    .done_o     (cnt_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      io_drv_q    <= 1'b0;
      a_q         <= '0;
      cs_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      rsp_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (REQ_VALID) begin
            state_q  <= StSetup;
            wr_q     <= REQ_WE;
            wdata_q  <= REQ_WDATA;
            a_q      <= REQ_ADDR;
            cs_q     <= 1'b0;
            // Reads assert OE from SETUP; writes drive IO from SETUP.
            oe_q     <= REQ_WE;
            we_q     <= 1'b1;
            io_drv_q <= REQ_WE;
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          if (wr_q) begin
            we_q <= 1'b0;
          end
        end
        StStrobe: begin
          if (cnt_done) begin
            we_q <= 1'b1;
            oe_q <= 1'b1;
            if (wr_q) begin
              state_q <= StHold;
            end else begin
              rd_data_q   <= IO;
              rsp_valid_q <= 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
              state_q     <= StHold;
`else
              state_q     <= StIdle;
              cs_q        <= 1'b1;
`endif
            end
          end
        end
        StHold: begin
          // Write data is held through HOLD and released on this edge.
          state_q  <= StIdle;
          cs_q     <= 1'b1;
          io_drv_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign REQ_READY = (state_q == StIdle);
  assign RSP_VALID = rsp_valid_q;
  assign RD_DATA   = rd_data_q;
  assign A         = a_q;
  assign CS        = cs_q;
  assign OE        = oe_q;
  assign WE        = we_q;
  assign IO        = io_drv_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Self-checking bench for sram_bus_ctrl with a behavioural SRAM and reference memory.
module tb_sram_bus_ctrl;

  localparam int W = 2;
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam int RdPeriod = W + 3;
`else
  localparam int RdPeriod = W + 2;
`endif
  localparam int WrPeriod = W + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [0:14] req_addr;
  logic [0:31] req_wdata;
  logic        rsp_valid;
  logic [0:31] rd_data;
  logic [0:14] a;
  wire  [0:31] io;
  logic        cs, oe, we;

  logic [0:31] sram_mem [0:32767];
  logic [0:31] ref_mem  [0:32767];
  logic        sram_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_bus_ctrl #(
    .WAIT_CYCLES (W),
    .ADDR_W      (15),
    .DATA_W      (32)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ_VALID (req_valid),
    .REQ_READY (req_ready),
    .REQ_WE    (req_we),
    .REQ_ADDR  (req_addr),
    .REQ_WDATA (req_wdata),
    .RSP_VALID (rsp_valid),
    .RD_DATA   (rd_data),
    .A         (a),
    .IO        (io),
    .CS        (cs),
    .OE        (oe),
    .WE        (we)
  );

  // Asynchronous SRAM: drives IO while selected and output-enabled, writes on WE rising.
  assign io = (!cs && !oe && we) ? sram_mem[a] : {32{1'bz}};
  always @(posedge we) if (sram_en && !cs) sram_mem[a] <= io;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_txn(input bit wr, input logic [0:14] addr, input logic [0:31] data);
    int n, we_low, oe_low, rsp_cnt, rsp_cyc, ready_cyc, cs_bad, a_bad, drv_bad;
    logic [0:31] rsp_data, exp_rd;
    exp_rd = ref_mem[addr];
    n = 0; we_low = 0; oe_low = 0; rsp_cnt = 0; rsp_cyc = -1; ready_cyc = -1;
    cs_bad = 0; a_bad = 0; drv_bad = 0; rsp_data = '0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = wr; req_addr = addr; req_wdata = data;
    @(posedge clk);
    for (int c = 1; c <= 30 && ready_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Inputs are don't-care once accepted.
        req_valid = 1'b0; req_we = 1'($urandom);
        req_addr = 15'($urandom); req_wdata = $urandom;
      end
      if (req_ready) ready_cyc = c;
      else begin
        if (cs !== 1'b0) cs_bad++;
        if (a !== addr) a_bad++;
        if (!we) we_low++;
        if (!oe) oe_low++;
        if (dut.io_drv_q !== wr) drv_bad++;
        if (wr && io !== data) drv_bad++;
      end
      if (rsp_valid) begin rsp_cnt++; rsp_cyc = c; rsp_data = rd_data; end
    end
    check("ready_cyc", 32'(ready_cyc), wr ? 32'(WrPeriod) : 32'(RdPeriod));
    check("we_low", 32'(we_low), wr ? 32'(W) : 32'd0);
    check("oe_low", 32'(oe_low), wr ? 32'd0 : 32'(W + 1));
    check("cs_busy", 32'(cs_bad), 32'd0);
    check("a_busy", 32'(a_bad), 32'd0);
    check("io_drive", 32'(drv_bad), 32'd0);
    check("rsp_cnt", 32'(rsp_cnt), wr ? 32'd0 : 32'd1);
    check("idle_strobes", {29'd0, cs, oe, we}, 32'd7);
    check("idle_drv", 32'(dut.io_drv_q), 32'd0);
    check("a_hold", 32'(a), 32'(addr));
    if (wr) begin
      ref_mem[addr] = data;
      check("sram_word", sram_mem[addr], data);
    end else begin
      check("rsp_cyc", 32'(rsp_cyc), 32'(W + 2));
      check("rd_data", rsp_data, exp_rd);
    end
  endtask

  task automatic b2b_reads();
    logic [0:14] addrs [3];
    int acc_cyc [3];
    int idx, nrsp, cyc, n;
    bit acc_pending;
    addrs[0] = 15'd1; addrs[1] = 15'd2; addrs[2] = 15'd3;
    idx = 0; nrsp = 0; cyc = 0; n = 0; acc_pending = 1'b0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_addr = addrs[0]; req_wdata = $urandom;
    while (nrsp < 3 && cyc < 60) begin
      if (acc_pending) begin
        acc_pending = 1'b0;
        idx++;
        if (idx < 3) req_addr = addrs[idx];
        else req_valid = 1'b0;
      end
      if (rsp_valid) begin
        check("b2b_data", rd_data, ref_mem[addrs[nrsp]]);
        check("b2b_lat", 32'(cyc - acc_cyc[nrsp]), 32'(W + 2));
        nrsp++;
      end
      if (req_valid && req_ready) begin acc_cyc[idx] = cyc; acc_pending = 1'b1; end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    check("b2b_count", 32'(nrsp), 32'd3);
    check("b2b_period0", 32'(acc_cyc[1] - acc_cyc[0]), 32'(RdPeriod));
    check("b2b_period1", 32'(acc_cyc[2] - acc_cyc[1]), 32'(RdPeriod));
  endtask

  initial begin
    int extra_rsp;
    for (int i = 0; i < 32768; i++) begin
      sram_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h9E37_79B9);
      ref_mem[i]  = 32'hA5A5_0000 ^ (32'(i) * 32'h9E37_79B9);
    end
    // Reset with a pending request that must be ignored.
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 15'd5; req_wdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check("rst_strobes", {29'd0, cs, oe, we}, 32'd7);
    check("rst_rsp", 32'(rsp_valid), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_a", 32'(a), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_drv", 32'(dut.io_drv_q), 32'd0);
    rst = 1'b0; req_valid = 1'b0; sram_en = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(cs), 32'd1);

    do_txn(1'b1, 15'd0, 32'h0000_0001);
    do_txn(1'b1, 15'h7FFF, 32'hDEAD_BEEF);
    do_txn(1'b0, 15'h7FFF, 32'h0);
    b2b_reads();

    // Reset while a read is in STROBE.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 15'd9;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("mid_oe_low", 32'(oe), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_strobes", {29'd0, cs, oe, we}, 32'd7);
    check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_drv", 32'(dut.io_drv_q), 32'd0);
    rst = 1'b0;
    extra_rsp = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) extra_rsp++; end
    check("mid_rst_no_rsp", 32'(extra_rsp), 32'd0);

    for (int i = 0; i < 24; i++) begin
      logic [0:14] ad;
      ad = 15'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ad = ad | 15'h7FF0;
      do_txn(1'($urandom_range(0, 1)), ad, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
